// File: rtl/perf_ctrl.sv
// Start/stop controller for a performance counter, with a two-edge delayed snapshot and a host read port.
// Define PERF_SAT_EN to end a session automatically when a counter saturates; ovf then reports it.
module perf_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_id,
   input  logic             start_wb,
   input  logic             stop_wb,
   input  logic             flush,
   input  logic [CNT_W-1:0] instr_cnt,
   input  logic [CNT_W-1:0] cycle_cnt,
   input  logic             rd_req,
   input  logic             rd_sel,
   output logic             str_ccnt,
   output logic             str_icnt,
   output logic             stp_cnt,
   output logic             busy,
   output logic             snap_vld,
   output logic             rd_ack,
   output logic [CNT_W-1:0] rd_data,
   output logic             ovf
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      RUN   = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             str_ccnt_nxt;
   logic             str_icnt_nxt;
   logic             stp_cnt_nxt;
   logic             cap_set;
   logic             clr_vld;
   logic             cap_pend;
   logic             cap_go;
   logic             rd_req_q;
   logic             sat;
   logic [CNT_W-1:0] snap_instr;
   logic [CNT_W-1:0] snap_cycle;

`ifdef PERF_SAT_EN
   assign sat = (&cycle_cnt) | (&instr_cnt);

   // Sticky until the next accepted start_id, which is exactly when str_ccnt is about to fire.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf <= 1'b0;
      end else if ((state == RUN) && sat) begin
         ovf <= 1'b1;
      end else if (str_ccnt_nxt) begin
         ovf <= 1'b0;
      end
   end
`else
   assign sat = 1'b0;
   assign ovf = 1'b0;
`endif

   always_comb begin
      state_nxt    = state;
      str_ccnt_nxt = 1'b0;
      str_icnt_nxt = 1'b0;
      stp_cnt_nxt  = 1'b0;
      cap_set      = 1'b0;
      clr_vld      = 1'b0;
      case (state)
         IDLE: begin
            if (start_id) begin
               state_nxt    = ARMED;
               str_ccnt_nxt = 1'b1;
            end
         end
         DONE: begin
            if (start_id) begin
               state_nxt    = ARMED;
               str_ccnt_nxt = 1'b1;
               clr_vld      = 1'b1;
            end
         end
         ARMED: begin
            if (flush || stop_wb) begin
               state_nxt   = IDLE;
               stp_cnt_nxt = 1'b1;
            end else if (start_wb) begin
               state_nxt    = RUN;
               str_icnt_nxt = 1'b1;
            end
         end
         RUN: begin
            if (stop_wb || sat) begin
               state_nxt   = DONE;
               stp_cnt_nxt = 1'b1;
               cap_set     = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // cap_pend/cap_go delay the snapshot two edges so the counter has seen stp_cnt and frozen.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         str_ccnt <= 1'b0;
         str_icnt <= 1'b0;
         stp_cnt  <= 1'b0;
         busy     <= 1'b0;
         cap_pend <= 1'b0;
         cap_go   <= 1'b0;
      end else begin
         state    <= state_nxt;
         str_ccnt <= str_ccnt_nxt;
         str_icnt <= str_icnt_nxt;
         stp_cnt  <= stp_cnt_nxt;
         busy     <= (state_nxt == ARMED) || (state_nxt == RUN);
         cap_pend <= cap_set;
         cap_go   <= cap_pend & ~clr_vld;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         snap_vld   <= 1'b0;
         snap_instr <= '0;
         snap_cycle <= '0;
      end else if (clr_vld) begin
         snap_vld <= 1'b0;
      end else if (cap_go) begin
         snap_vld   <= 1'b1;
         snap_instr <= instr_cnt;
         snap_cycle <= cycle_cnt;
      end
   end

   // One ack per rd_req assertion: only a low-to-high transition is acknowledged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_req_q <= 1'b0;
         rd_ack   <= 1'b0;
         rd_data  <= '0;
      end else begin
         rd_req_q <= rd_req;
         if (rd_req && !rd_req_q) begin
            rd_ack <= 1'b1;
            if (snap_vld) begin
               rd_data <= rd_sel ? snap_cycle : snap_instr;
            end else begin
               rd_data <= rd_sel ? cycle_cnt : instr_cnt;
            end
         end else begin
            rd_ack  <= 1'b0;
            rd_data <= '0;
         end
      end
   end

endmodule
